// File: rtl/write_fsm.sv
// -----------------------------------------------------------------------------
// write_fsm
//   Sequences the write-back of one ALU matrix result into the register file.
//   A request (w_en) arms the FSM, which waits for the ALU result, then for a
//   destination register from the keypad, then streams ELEMS consecutive
//   element writes. An ALU overflow aborts the sequence with an err pulse.
//
// Parameters
//   ELEMS     number of matrix elements written per result (1..15)
//
// Ports
//   clk       in   rising-edge clock
//   nrst      in   asynchronous active-low reset
//   w_en      in   start a write-back sequence (sampled in IDLE only)
//   alu_done  in   ALU result ready pulse (sampled in WAIT_ALU only)
//   alu_ovf   in   ALU overflow flag, qualified by alu_done
//   reg_num   in   destination register from keypad, 0 = no selection
//   reg_sel   out  register file write select (0 outside WRITE)
//   wr_en     out  register file write strobe, one element per cycle
//   elem_idx  out  element index being written (0 outside WRITE)
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse on successful completion
//   err       out  one-cycle pulse on an aborted (overflow) sequence
// -----------------------------------------------------------------------------
module write_fsm #(
    parameter int ELEMS = 9
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       w_en,
    input  logic       alu_done,
    input  logic       alu_ovf,
    input  logic [2:0] reg_num,
    output logic [2:0] reg_sel,
    output logic       wr_en,
    output logic [3:0] elem_idx,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ALU  = 3'd1,
        WAIT_DEST = 3'd2,
        WRITE     = 3'd3,
        DONE      = 3'd4,
        ERR       = 3'd5
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(ELEMS - 1);

    state_t     r_state;
    logic [2:0] r_dest;
    logic [3:0] r_cnt;
    logic       r_wr_en;
    logic       r_busy;
    logic       r_done;
    logic       r_err;

    // All outputs are registers updated together with the state, so every
    // output already reflects the state it belongs to. The destination and
    // counter registers are only non-zero while in WRITE, which lets them
    // drive reg_sel / elem_idx directly.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_dest  <= 3'b000;
            r_cnt   <= 4'h0;
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_en) begin
                        r_state <= WAIT_ALU;
                        r_busy  <= 1'b1;
                    end
                end
                WAIT_ALU: begin
                    if (alu_done) begin
                        if (alu_ovf) begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= WAIT_DEST;
                        end
                    end
                end
                WAIT_DEST: begin
                    if (reg_num != 3'b000) begin
                        r_state <= WRITE;
                        r_dest  <= reg_num;
                        r_cnt   <= 4'h0;
                        r_wr_en <= 1'b1;
                    end
                end
                WRITE: begin
                    // Leave on the cycle the last element is being written.
                    if (r_cnt == LAST_IDX) begin
                        r_state <= DONE;
                        r_dest  <= 3'b000;
                        r_cnt   <= 4'h0;
                        r_wr_en <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                DONE, ERR: begin
                    // w_en is deliberately not looked at here; a new request
                    // has to be seen in IDLE.
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_dest  <= 3'b000;
                    r_cnt   <= 4'h0;
                    r_wr_en <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign reg_sel  = r_dest;
    assign elem_idx = r_cnt;
    assign wr_en    = r_wr_en;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_write_fsm.sv
// -----------------------------------------------------------------------------
// tb_write_fsm
//   Scoreboard bench for write_fsm. Stimulus pushes the expected output events
//   (write / done / err) into a queue; a monitor pops and compares whenever the
//   ELEMS=9 instance presents an event. ELEMS=1 and ELEMS=15 instances share
//   the inputs and are counted during a dedicated phase.
// -----------------------------------------------------------------------------
module tb_write_fsm;

    localparam logic [1:0] K_WR   = 2'd0;
    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;
    localparam logic [1:0] K_BAD  = 2'd3;

    typedef struct packed {
        logic       busy;
        logic [1:0] kind;
        logic [2:0] sel;
        logic [3:0] idx;
    } ev_t;

    logic       clk;
    logic       nrst;
    logic       w_en;
    logic       alu_done;
    logic       alu_ovf;
    logic [2:0] reg_num;

    logic [2:0] reg_sel9, reg_sel1, reg_sel15;
    logic       wr_en9, wr_en1, wr_en15;
    logic [3:0] elem_idx9, elem_idx1, elem_idx15;
    logic       busy9, busy1, busy15;
    logic       done9, done1, done15;
    logic       err9, err1, err15;

    int   checks   = 0;
    int   failures = 0;
    ev_t  sb[$];

    logic cnt_en = 1'b0;
    int   n1, n15;
    logic [3:0] last1, last15;

    write_fsm #(.ELEMS(9)) dut (
        .clk(clk), .nrst(nrst), .w_en(w_en), .alu_done(alu_done),
        .alu_ovf(alu_ovf), .reg_num(reg_num), .reg_sel(reg_sel9),
        .wr_en(wr_en9), .elem_idx(elem_idx9), .busy(busy9),
        .done(done9), .err(err9)
    );

    write_fsm #(.ELEMS(1)) dut1 (
        .clk(clk), .nrst(nrst), .w_en(w_en), .alu_done(alu_done),
        .alu_ovf(alu_ovf), .reg_num(reg_num), .reg_sel(reg_sel1),
        .wr_en(wr_en1), .elem_idx(elem_idx1), .busy(busy1),
        .done(done1), .err(err1)
    );

    write_fsm #(.ELEMS(15)) dut15 (
        .clk(clk), .nrst(nrst), .w_en(w_en), .alu_done(alu_done),
        .alu_ovf(alu_ovf), .reg_num(reg_num), .reg_sel(reg_sel15),
        .wr_en(wr_en15), .elem_idx(elem_idx15), .busy(busy15),
        .done(done15), .err(err15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output event of the ELEMS=9 instance must match the
    // oldest expected event.
    always @(negedge clk) begin
        ev_t act;
        ev_t exp;
        if (wr_en9 || done9 || err9) begin
            act.busy = busy9;
            act.sel  = reg_sel9;
            act.idx  = elem_idx9;
            if (wr_en9 && !done9 && !err9)      act.kind = K_WR;
            else if (done9 && !wr_en9 && !err9) act.kind = K_DONE;
            else if (err9 && !wr_en9 && !done9) act.kind = K_ERR;
            else                                act.kind = K_BAD;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: got 0x%0h expected none at %0t", act, $time);
            end else begin
                exp = sb.pop_front();
                checks--;
                check("event", 32'(act), 32'(exp));
            end
        end
    end

    // Write counters for the ELEMS=1 / ELEMS=15 instances.
    always @(negedge clk) begin
        if (!cnt_en) begin
            n1 = 0; n15 = 0; last1 = 4'hf; last15 = 4'hf;
        end else begin
            if (wr_en1)  begin n1++;  last1  = elem_idx1;  end
            if (wr_en15) begin n15++; last15 = elem_idx15; end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input logic [2:0] sel, input int n, input bit with_done);
        for (int i = 0; i < n; i++) sb.push_back('{1'b1, K_WR, sel, 4'(i)});
        if (with_done) sb.push_back('{1'b1, K_DONE, 3'b000, 4'h0});
    endtask

    task automatic start_seq(input logic ovf);
        w_en = 1'b1;
        step();
        w_en = 1'b0;
        step();
        alu_done = 1'b1;
        alu_ovf  = ovf;
        step();
        alu_done = 1'b0;
        alu_ovf  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while (busy9 && n < max) begin
            step();
            n++;
        end
        if (busy9) check({name, "_timeout"}, 32'(busy9), 32'd0);
    endtask

    task automatic wait_write_idx(input string name, input logic [3:0] idx);
        int n = 0;
        while (!(wr_en9 && elem_idx9 == idx) && n < 50) begin
            step();
            n++;
        end
        if (!(wr_en9 && elem_idx9 == idx)) check({name, "_timeout"}, 32'(elem_idx9), 32'(idx));
    endtask

    // Waits for the done pulse, then asserts w_en only during DONE.
    task automatic finish_with_poke(input string name);
        int n = 0;
        while (!done9 && n < 50) begin
            step();
            n++;
        end
        check({name, "_done_seen"}, 32'(done9), 32'd1);
        w_en = 1'b1;
        step();
        w_en = 1'b0;
        step();
        step();
        check({name, "_no_restart_busy"}, 32'(busy9), 32'd0);
    endtask

    initial begin
        nrst = 1'b0; w_en = 1'b0; alu_done = 1'b0; alu_ovf = 1'b0; reg_num = 3'd0;
        #3;
        check("rst_reg_sel",  32'(reg_sel9),  32'd0);
        check("rst_wr_en",    32'(wr_en9),    32'd0);
        check("rst_elem_idx", 32'(elem_idx9), 32'd0);
        check("rst_busy",     32'(busy9),     32'd0);
        check("rst_done_err", 32'({done9, err9}), 32'd0);
        step();
        nrst = 1'b1;
        step();
        step();
        check("post_rst_busy", 32'(busy9), 32'd0);

        // Nominal burst to register 5.
        push_burst(3'd5, 9, 1'b1);
        reg_num = 3'd5;
        start_seq(1'b0);
        check("nom_busy", 32'(busy9), 32'd1);
        wait_idle("nom", 40);
        reg_num = 3'd0;
        check("nom_idle", 32'(busy9), 32'd0);
        check("nom_sb_empty", 32'(sb.size()), 32'd0);

        // Overflow abort, with w_en pulsed during ERR.
        sb.push_back('{1'b1, K_ERR, 3'b000, 4'h0});
        reg_num = 3'd4;
        start_seq(1'b1);
        w_en = 1'b1;
        step();
        w_en = 1'b0;
        step();
        step();
        check("ovf_no_restart_busy", 32'(busy9), 32'd0);
        check("ovf_sb_empty", 32'(sb.size()), 32'd0);
        reg_num = 3'd0;

        // Hold in WAIT_DEST with reg_num=0, then select register 3.
        push_burst(3'd3, 9, 1'b1);
        start_seq(1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("hold_busy", 32'(busy9), 32'd1);
        end
        reg_num = 3'd3;
        finish_with_poke("hold");
        reg_num = 3'd0;
        check("hold_sb_empty", 32'(sb.size()), 32'd0);

        // Input noise during WRITE.
        push_burst(3'd5, 9, 1'b1);
        reg_num = 3'd5;
        start_seq(1'b0);
        wait_write_idx("noise", 4'd4);
        reg_num  = 3'd2;
        w_en     = 1'b1;
        alu_done = 1'b1;
        alu_ovf  = 1'b1;
        step();
        w_en = 1'b0; alu_done = 1'b0; alu_ovf = 1'b0;
        step();
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        wait_idle("noise", 40);
        reg_num = 3'd0;
        for (int i = 0; i < 5; i++) step();
        check("noise_idle", 32'(busy9), 32'd0);
        check("noise_sb_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset in the middle of a burst.
        push_burst(3'd6, 6, 1'b0);
        reg_num = 3'd6;
        start_seq(1'b0);
        wait_write_idx("arst", 4'd6);
        #1 nrst = 1'b0;
        #1;
        check("arst_wr_en",    32'(wr_en9),    32'd0);
        check("arst_busy",     32'(busy9),     32'd0);
        check("arst_reg_sel",  32'(reg_sel9),  32'd0);
        check("arst_elem_idx", 32'(elem_idx9), 32'd0);
        check("arst_sb_empty", 32'(sb.size()), 32'd0);
        w_en = 1'b1;
        step();
        w_en = 1'b0;
        step();
        nrst = 1'b1;
        reg_num = 3'd1;
        for (int i = 0; i < 3; i++) step();
        check("arst_no_resume", 32'({busy9, wr_en9}), 32'd0);
        push_burst(3'd1, 9, 1'b1);
        start_seq(1'b0);
        wait_idle("arst_fresh", 40);
        reg_num = 3'd0;
        check("arst_fresh_sb_empty", 32'(sb.size()), 32'd0);

        // ELEMS=1 / ELEMS=15 instances run the same sequence.
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        step();
        cnt_en = 1'b1;
        push_burst(3'd7, 9, 1'b1);
        reg_num = 3'd7;
        start_seq(1'b0);
        begin
            int n = 0;
            while ((busy9 || busy1 || busy15) && n < 60) begin
                step();
                n++;
            end
            if (busy9 || busy1 || busy15) check("elems_timeout", 32'({busy9, busy1, busy15}), 32'd0);
        end
        step();
        check("elems1_count",  32'(n1),     32'd1);
        check("elems1_last",   32'(last1),  32'd0);
        check("elems15_count", 32'(n15),    32'd15);
        check("elems15_last",  32'(last15), 32'd14);
        cnt_en = 1'b0;
        reg_num = 3'd0;
        check("elems_sb_empty", 32'(sb.size()), 32'd0);

        for (int i = 0; i < 3; i++) step();
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/write_fsm.md
WRITE_FSM -- requirements
Module: write_fsm

Interface
REQ-001 SHALL have parameter ELEMS, default 9, number of matrix elements written per result (legal range 1..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port w_en  input  1  request to start a write-back sequence.
REQ-005 SHALL have port alu_done  input  1  ALU result ready, single-cycle pulse.
REQ-006 SHALL have port alu_ovf  input  1  ALU overflow flag, qualified by alu_done.
REQ-007 SHALL have port reg_num  input  3  destination register from keypad; 3'b000 means no selection.
REQ-008 SHALL have port reg_sel  output  3  register file write select.
REQ-009 SHALL have port wr_en  output  1  register file write strobe, one element per cycle.
REQ-010 SHALL have port elem_idx  output  4  element index being written.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-013 SHALL have port err  output  1  one-cycle pulse on an aborted (overflow) sequence.

Function
REQ-014 SHALL implement states IDLE, WAIT_ALU, WAIT_DEST, WRITE, DONE, ERR; state updates on rising clk only.
REQ-015 SHALL transition IDLE->WAIT_ALU when w_en=1; otherwise hold IDLE.
REQ-016 SHALL, in WAIT_ALU: alu_done=1 and alu_ovf=1 -> ERR; alu_done=1 and alu_ovf=0 -> WAIT_DEST; else hold.
REQ-017 SHALL, in WAIT_DEST: reg_num!=0 -> WRITE, latching reg_num into internal dest register and clearing element counter to 0; reg_num=0 -> hold.
REQ-018 SHALL, in WRITE: assert wr_en=1, reg_sel=latched dest, elem_idx=counter; counter increments by 1 each cycle.
REQ-019 SHALL leave WRITE for DONE on the cycle counter==ELEMS-1, so exactly ELEMS consecutive wr_en cycles with elem_idx 0..ELEMS-1 occur.
REQ-020 SHALL transition DONE->IDLE and ERR->IDLE unconditionally after one cycle.
REQ-021 SHALL drive done=1 only in DONE and err=1 only in ERR.
REQ-022 SHALL decode all outputs from state and internal registers only (Moore); outside WRITE, wr_en=0, reg_sel=3'b000, elem_idx=4'h0.
REQ-023 SHALL ignore w_en in every state other than IDLE (no queuing of requests).
REQ-024 SHALL ignore alu_done and alu_ovf in every state other than WAIT_ALU.
REQ-025 SHALL ignore reg_num changes once latched; reg_sel remains constant for the full WRITE burst.
REQ-026 SHALL, with ELEMS=1, perform a single wr_en cycle with elem_idx=0 then go to DONE.
REQ-027 SHALL, if w_en=1 in DONE or ERR, not start a new sequence; IDLE must be re-entered and w_en sampled there.

Reset
REQ-028 SHALL, on nrst=0, immediately force state=IDLE, dest register=3'b000, counter=0 regardless of clk.
REQ-029 SHALL during and after reset drive reg_sel=3'b000, wr_en=0, elem_idx=4'h0, busy=0, done=0, err=0.
REQ-030 SHALL, on reset asserted mid-WRITE, drop wr_en in the same cycle and not resume the burst after reset release.

Verification
REQ-031 SHALL cover nominal: w_en pulse, alu_done=1 ovf=0, reg_num=3'd5 -> 9 cycles wr_en=1, reg_sel=5, elem_idx 0..8, then done=1 one cycle, busy=0 after.
REQ-032 SHALL cover overflow: w_en, then alu_done=1 alu_ovf=1 -> err=1 one cycle, zero wr_en cycles, back to IDLE.
REQ-033 SHALL cover hold conditions: reg_num=0 for 20 cycles in WAIT_DEST -> no wr_en, busy stays 1; then reg_num=3 -> burst with reg_sel=3.
REQ-034 SHALL cover input noise: reg_num changed 5->2 at elem_idx=4, w_en and alu_done pulsed during WRITE -> reg_sel stays 5, burst length stays 9, no restart.
REQ-035 SHALL cover async reset at elem_idx=6 -> wr_en=0 and busy=0 without a clk edge; after release a fresh w_en sequence with reg_num=1 completes normally.
REQ-036 SHALL cover ELEMS=1 and ELEMS=15 builds -> exactly 1 and 15 write cycles respectively, elem_idx final values 0 and 14.
